// File: rtl/exec_cc_stage.sv
// rtl/exec_cc_stage.sv - Y86-64 execute back end: condition codes, branch condition, E->M register
module exec_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             m_exception,
  input  logic             w_exception,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic             e_cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE
);

  localparam logic [3:0] ICODE_CMOV = 4'd2;
  localparam logic [3:0] ICODE_OPQ  = 4'd6;
  localparam logic [3:0] ICODE_JXX  = 4'd7;
  localparam logic [3:0] ICODE_NOP  = 4'd1;

  logic zf_n;
  logic sf_n;
  logic of_n;
  logic upd;
  logic cond;
  logic sf_xor_of;

  // Flags the current ALU result would produce if committed.
  assign zf_n = (alu_result == '0);
  assign sf_n = alu_result[WIDTH-1];
  assign of_n = alu_overflow;

  // Only a live OPq commits flags; an excepting older instruction or a stall
  // suppresses the update for good, it is never replayed later.
  assign upd = e_valid & (e_icode == ICODE_OPQ) & ~m_exception & ~w_exception & ~m_stall;

  // Architectural condition-code register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (upd) begin
      cc_zf <= zf_n;
      cc_sf <= sf_n;
      cc_of <= of_n;
    end
  end

  assign sf_xor_of = cc_sf ^ cc_of;

  // Condition select from the registered flags, not the in-flight ones.
  always_comb begin
    cond = 1'b0;
    case (e_ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = sf_xor_of | cc_zf;
      4'd2:    cond = sf_xor_of;
      4'd3:    cond = cc_zf;
      4'd4:    cond = ~cc_zf;
      4'd5:    cond = ~sf_xor_of;
      4'd6:    cond = ~sf_xor_of & ~cc_zf;
      default: cond = 1'b0;
    endcase
  end

  assign e_cnd = ((e_icode == ICODE_JXX) || (e_icode == ICODE_CMOV)) ? cond : 1'b0;

  // E->M pipeline register; bubble outranks stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_valid <= 1'b0;
      M_icode <= ICODE_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
    end else if (m_bubble) begin
      M_valid <= 1'b0;
      M_icode <= ICODE_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
    end else if (!m_stall) begin
      M_valid <= e_valid;
      M_icode <= e_icode;
      M_cnd   <= e_cnd;
      M_valE  <= alu_result;
    end
  end

endmodule

// File: tb/tb_exec_cc_stage.sv
// tb/tb_exec_cc_stage.sv - directed self-checking bench for exec_cc_stage
module tb_exec_cc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] alu_result;
  logic        alu_overflow;
  logic        m_exception;
  logic        w_exception;
  logic        m_stall;
  logic        m_bubble;
  logic        e_cnd;
  logic        cc_zf, cc_sf, cc_of;
  logic        M_valid;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;

  int n_checks = 0;
  int n_errors = 0;

  exec_cc_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .m_exception(m_exception), .w_exception(w_exception),
    .m_stall(m_stall), .m_bubble(m_bubble), .e_cnd(e_cnd),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] res, input logic ov);
    e_valid      = v;
    e_icode      = ic;
    e_ifun       = fn;
    alu_result   = res;
    alu_overflow = ov;
  endtask

  task automatic check_cc(input string tag, input logic [2:0] exp);
    check(tag, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, exp});
  endtask

  initial begin
    rst = 1'b0;
    m_exception = 1'b0; w_exception = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    drive(1'b0, 4'd1, 4'd0, 64'd0, 1'b0);

    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    check_cc("rst_cc", 3'b100);
    check("rst_M_icode", M_icode, 64'd1);
    check("rst_M_valid", M_valid, 64'd0);
    check("rst_M_valE", M_valE, 64'd0);
    e_icode = 4'd7; e_ifun = 4'd3;
    #1 check("rst_je", e_cnd, 64'd1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // nonzero positive result clears ZF; OPq never asserts e_cnd
    drive(1'b1, 4'd6, 4'd1, 64'd7, 1'b0);
    #1 check("opq_cnd_forced0", e_cnd, 64'd0);
    tick();
    check_cc("pos_cc", 3'b000);

    // subtract to zero, then jXX
    drive(1'b1, 4'd6, 4'd1, 64'd0, 1'b0);
    tick();
    check_cc("zero_cc", 3'b100);
    check("zero_M_valid", M_valid, 64'd1);
    check("zero_M_icode", M_icode, 64'd6);
    drive(1'b1, 4'd7, 4'd3, 64'h55, 1'b0);
    #1 check("zero_je", e_cnd, 64'd1);
    e_ifun = 4'd4;
    #1 check("zero_jne", e_cnd, 64'd0);
    tick();
    check("zero_M_cnd", M_cnd, 64'd0);
    check("zero_M_icode_j", M_icode, 64'd7);
    check_cc("jxx_no_cc_upd", 3'b100);

    // signed overflow
    drive(1'b1, 4'd6, 4'd0, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    check_cc("ovf_cc", 3'b011);
    drive(1'b1, 4'd2, 4'd2, 64'd3, 1'b0);
    #1 check("ovf_l", e_cnd, 64'd0);
    e_ifun = 4'd1;
    #1 check("ovf_le", e_cnd, 64'd0);
    e_ifun = 4'd6;
    #1 check("ovf_g", e_cnd, 64'd1);
    e_ifun = 4'd5;
    #1 check("ovf_ge", e_cnd, 64'd1);
    tick();
    check("ovf_M_cnd", M_cnd, 64'd1);
    check("ovf_M_icode", M_icode, 64'd2);

    // exception suppression
    drive(1'b1, 4'd6, 4'd1, 64'd0, 1'b0);
    tick();
    check_cc("exc_prior_cc", 3'b100);
    drive(1'b1, 4'd6, 4'd0, 64'd5, 1'b0);
    m_exception = 1'b1;
    tick();
    check_cc("mexc_cc", 3'b100);
    check("mexc_M_valE", M_valE, 64'd5);
    m_exception = 1'b0; w_exception = 1'b1;
    tick();
    check_cc("wexc_cc", 3'b100);
    check("wexc_M_valE", M_valE, 64'd5);
    w_exception = 1'b0;
    drive(1'b1, 4'd1, 4'd0, 64'd9, 1'b0);
    tick();
    check_cc("exc_no_deferred", 3'b100);

    // invalid execute slot
    drive(1'b0, 4'd6, 4'd0, 64'd5, 1'b0);
    tick();
    check_cc("inv_cc", 3'b100);
    check("inv_M_valid", M_valid, 64'd0);
    check("inv_M_icode", M_icode, 64'd6);
    check("inv_M_valE", M_valE, 64'd5);

    // stall holds everything
    drive(1'b1, 4'd6, 4'd0, 64'hDEAD, 1'b0);
    tick();
    check("stall_load", M_valE, 64'hDEAD);
    check_cc("stall_pre_cc", 3'b000);
    m_stall = 1'b1;
    drive(1'b1, 4'd6, 4'd0, 64'd0, 1'b0);
    tick();
    check("stall1_valE", M_valE, 64'hDEAD);
    check_cc("stall1_cc", 3'b000);
    drive(1'b1, 4'd7, 4'd0, 64'd1, 1'b1);
    tick();
    check("stall2_valE", M_valE, 64'hDEAD);
    check("stall2_icode", M_icode, 64'd6);
    drive(1'b1, 4'd6, 4'd0, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    check("stall3_valE", M_valE, 64'hDEAD);
    check_cc("stall3_cc", 3'b000);
    m_bubble = 1'b1;
    drive(1'b1, 4'd7, 4'd0, 64'h1234, 1'b0);
    tick();
    check("bub_M_icode", M_icode, 64'd1);
    check("bub_M_valid", M_valid, 64'd0);
    check("bub_M_valE", M_valE, 64'd0);
    check("bub_M_cnd", M_cnd, 64'd0);
    m_stall = 1'b0; m_bubble = 1'b0;

    // illegal conditions and non-branch icodes
    e_icode = 4'd7;
    for (int f = 7; f < 16; f++) begin
      e_ifun = f[3:0];
      #1 check($sformatf("illegal_ifun_%0d", f), e_cnd, 64'd0);
    end
    e_ifun = 4'd0;
    #1 check("jmp_always", e_cnd, 64'd1);
    e_icode = 4'd6;
    #1 check("opq_ifun0_cnd", e_cnd, 64'd0);

    // reset in the middle of a stall
    drive(1'b1, 4'd6, 4'd0, 64'h8000_0000_0000_0000, 1'b0);
    tick();
    check_cc("mid_pre_cc", 3'b010);
    m_stall = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_cc("mid_rst_cc", 3'b100);
    check("mid_rst_M_valid", M_valid, 64'd0);
    check("mid_rst_M_icode", M_icode, 64'd1);
    check("mid_rst_M_valE", M_valE, 64'd0);
    tick();
    rst = 1'b0; m_stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
